// File: rtl/bcd_count_n_pkg.sv
// Shared constants and helpers for the BCD counter slice.
package bcd_count_n_pkg;

    localparam int BCD_W            = 4;
    localparam int BCD_MAX_DIGIT    = 9;
    localparam int DEFAULT_PRESCALE = 33554432;

    // Saturate a single BCD digit to 9; codes 10..15 are not valid BCD.
    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
        return (d > BCD_W'(BCD_MAX_DIGIT)) ? BCD_W'(BCD_MAX_DIGIT) : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: increment with carry-out, decrement with borrow-out.
module bcd_digit
    import bcd_count_n_pkg::*;
(
    input  logic [BCD_W-1:0] value,
    input  logic             inc,
    input  logic             dec,
    input  logic             clamp,
    output logic [BCD_W-1:0] next_value,
    output logic             carry,
    output logic             borrow
);

    logic [BCD_W-1:0] value_c;

    // Next digit value; carry/borrow ripple to the next more significant digit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        value_c    = clamp ? clamp_digit(value) : value;
        next_value = value_c;
        carry      = 1'b0;
        borrow     = 1'b0;
        if (inc) begin
            if (value_c == BCD_W'(BCD_MAX_DIGIT)) begin
                next_value = '0;
                carry      = 1'b1;
            end else begin
                next_value = value_c + 1'b1;
            end
        end else if (dec) begin
            if (value_c == '0) begin
                next_value = BCD_W'(BCD_MAX_DIGIT);
                borrow     = 1'b1;
            end else begin
                next_value = value_c - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_count_n.sv
// Multi-digit BCD up/down counter stepped by a clock-enable prescaler.
module bcd_count_n
    import bcd_count_n_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      run,
    input  logic                      up,
    input  logic                      load,
    input  logic [DIGITS*BCD_W-1:0]   load_value,
    input  logic [DIGITS*BCD_W-1:0]   max_count,
    output logic [DIGITS*BCD_W-1:0]   digits,
    output logic                      tc,
    output logic                      step
);

    localparam int W  = DIGITS * BCD_W;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic [W-1:0]  max_c;
    logic [W-1:0]  load_c;
    logic [W-1:0]  count_next;
    logic [DIGITS:0] inc_chain;
    logic [DIGITS:0] dec_chain;
    logic          step_en;
    logic          at_max;
    logic          at_zero;
    logic          wrap;
    logic          unused_top_ripple;

    // Sanitise terminal and load values digit by digit.
    always_comb begin
        max_c  = '0;
        load_c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            max_c[i*BCD_W +: BCD_W]  = clamp_digit(max_count[i*BCD_W +: BCD_W]);
            load_c[i*BCD_W +: BCD_W] = clamp_digit(load_value[i*BCD_W +: BCD_W]);
        end
    end

    // Step decode and wrap detection; BCD ordering matches binary ordering of valid codes.
    always_comb begin
        step_en      = run & (presc == PS_LAST);
        at_max       = (digits >= max_c);
        at_zero      = (digits == '0);
        wrap         = up ? at_max : at_zero;
        inc_chain[0] = up & ~at_max;
        dec_chain[0] = ~up & ~at_zero;
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .value      (digits[g*BCD_W +: BCD_W]),
                .inc        (inc_chain[g]),
                .dec        (dec_chain[g]),
                .clamp      (1'b1),
                .next_value (count_next[g*BCD_W +: BCD_W]),
                .carry      (inc_chain[g+1]),
                .borrow     (dec_chain[g+1])
            );
        end
    endgenerate

    // Ripple out of the top digit is never needed: wrap is decided by at_max/at_zero.
    assign unused_top_ripple = inc_chain[DIGITS] ^ dec_chain[DIGITS];

    // Prescaler, count and registered step/tc pulses; load overrides any step.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
        if (!RST_N) begin
            presc  <= '0;
            digits <= '0;
            step   <= 1'b0;
            tc     <= 1'b0;
        end else if (load) begin
            presc  <= '0;
            digits <= load_c;
            step   <= 1'b0;
            tc     <= 1'b0;
        end else if (run) begin
            presc <= (presc == PS_LAST) ? '0 : presc + 1'b1;
            step  <= step_en;
            tc    <= step_en & wrap;
            if (step_en) begin
                if (wrap) digits <= up ? '0 : max_c;
                else      digits <= count_next;
            end
        end else begin
            step <= 1'b0;
            tc   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_count_n.sv
// Bench for bcd_count_n: three instances (2 digits/prescale 4, 2 digits/prescale 1,
// 4 digits/prescale 2) checked every cycle against a decimal-integer model.
module tb_bcd_count_n;

    logic        CLK;
    logic        RST_N;
    logic        run_i  [3];
    logic        up_i   [3];
    logic        load_i [3];
    logic [31:0] lv_i   [3];
    logic [31:0] mx_i   [3];

    logic [7:0]  d0, d1;
    logic [15:0] d2;
    logic        s0, s1, s2, t0, t1, t2;
    logic [31:0] dout   [3];
    logic        step_o [3];
    logic        tc_o   [3];

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  cmp_en = 0;

    int  m_cnt  [3];
    int  m_pre  [3];
    bit  m_step [3];
    bit  m_tc   [3];

    bcd_count_n #(.DIGITS(2), .PRESCALE(4)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .run(run_i[0]), .up(up_i[0]), .load(load_i[0]),
        .load_value(lv_i[0][7:0]), .max_count(mx_i[0][7:0]),
        .digits(d0), .tc(t0), .step(s0));

    bcd_count_n #(.DIGITS(2), .PRESCALE(1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .run(run_i[1]), .up(up_i[1]), .load(load_i[1]),
        .load_value(lv_i[1][7:0]), .max_count(mx_i[1][7:0]),
        .digits(d1), .tc(t1), .step(s1));

    bcd_count_n #(.DIGITS(4), .PRESCALE(2)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .run(run_i[2]), .up(up_i[2]), .load(load_i[2]),
        .load_value(lv_i[2][15:0]), .max_count(mx_i[2][15:0]),
        .digits(d2), .tc(t2), .step(s2));

    assign dout[0] = {24'h0, d0};
    assign dout[1] = {24'h0, d1};
    assign dout[2] = {16'h0, d2};
    assign step_o[0] = s0;
    assign step_o[1] = s1;
    assign step_o[2] = s2;
    assign tc_o[0] = t0;
    assign tc_o[1] = t1;
    assign tc_o[2] = t2;

    always #5 CLK = ~CLK;

    function automatic int nd_of(input int i);
        return (i == 2) ? 4 : 2;
    endfunction

    function automatic int ps_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    // Decimal value of a BCD word, digits above 9 read as 9.
    function automatic int bcd_to_int(input logic [31:0] v, input int nd);
        int sum = 0;
        int mul = 1;
        for (int d = 0; d < nd; d++) begin
            int dig = int'(v[d*4 +: 4]);
            if (dig > 9) dig = 9;
            sum += dig * mul;
            mul *= 10;
        end
        return sum;
    endfunction

    function automatic logic [31:0] int_to_bcd(input int n, input int nd);
        logic [31:0] r = '0;
        int x = n;
        for (int d = 0; d < nd; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Behavioural model: count held as a decimal integer.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i]  <= 0;
                m_pre[i]  <= 0;
                m_step[i] <= 1'b0;
                m_tc[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int  maxv;
                bit  st;
                maxv = bcd_to_int(mx_i[i], nd_of(i));
                if (load_i[i]) begin
                    m_cnt[i]  <= bcd_to_int(lv_i[i], nd_of(i));
                    m_pre[i]  <= 0;
                    m_step[i] <= 1'b0;
                    m_tc[i]   <= 1'b0;
                end else if (run_i[i]) begin
                    st = (m_pre[i] == ps_of(i) - 1);
                    m_pre[i]  <= st ? 0 : m_pre[i] + 1;
                    m_step[i] <= st;
                    m_tc[i]   <= 1'b0;
                    if (st) begin
                        if (up_i[i]) begin
                            if (m_cnt[i] >= maxv) begin
                                m_cnt[i] <= 0;
                                m_tc[i]  <= 1'b1;
                            end else begin
                                m_cnt[i] <= m_cnt[i] + 1;
                            end
                        end else begin
                            if (m_cnt[i] == 0) begin
                                m_cnt[i] <= maxv;
                                m_tc[i]  <= 1'b1;
                            end else begin
                                m_cnt[i] <= m_cnt[i] - 1;
                            end
                        end
                    end
                end else begin
                    m_step[i] <= 1'b0;
                    m_tc[i]   <= 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge CLK) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model_digits%0d", i), dout[i], int_to_bcd(m_cnt[i], nd_of(i)));
                check($sformatf("model_step%0d", i), {31'h0, step_o[i]}, {31'h0, m_step[i]});
                check($sformatf("model_tc%0d", i), {31'h0, tc_o[i]}, {31'h0, m_tc[i]});
            end
        end
    end

    initial begin
        CLK   = 1'b0;
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_i[i] = 1'b0; up_i[i] = 1'b0; load_i[i] = 1'b0;
            lv_i[i]  = '0;   mx_i[i] = '0;
        end
        #1 RST_N = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_digits%0d", i), dout[i], 32'h0);
            check($sformatf("reset_step%0d", i), {31'h0, step_o[i]}, 32'h0);
            check($sformatf("reset_tc%0d", i), {31'h0, tc_o[i]}, 32'h0);
        end
        @(negedge CLK);
        RST_N  = 1'b1;
        cmp_en = 1'b1;

        // Instance 0: up count 00..59 with prescale 4.
        mx_i[0] = 32'h59; up_i[0] = 1'b1; run_i[0] = 1'b1;
        tick(4);
        check("up_first", dout[0], 32'h01);
        check("up_first_step", {31'h0, s0}, 32'h1);
        tick(4 * 58);
        check("up_59", dout[0], 32'h59);
        check("up_59_tc", {31'h0, t0}, 32'h0);
        tick(4);
        check("up_wrap", dout[0], 32'h00);
        check("up_wrap_tc", {31'h0, t0}, 32'h1);
        tick(1);
        check("tc_width", {31'h0, t0}, 32'h0);
        tick(2);

        // Load coincident with a step.
        load_i[0] = 1'b1; lv_i[0] = 32'h45;
        tick(1);
        load_i[0] = 1'b0;
        check("load_val", dout[0], 32'h45);
        check("load_step", {31'h0, s0}, 32'h0);
        check("load_tc", {31'h0, t0}, 32'h0);
        tick(4);
        check("after_load", dout[0], 32'h46);

        // Lowered max and max above 99.
        load_i[0] = 1'b1; lv_i[0] = 32'h50;
        tick(1);
        load_i[0] = 1'b0; mx_i[0] = 32'h30;
        tick(4);
        check("over_max", dout[0], 32'h00);
        check("over_max_tc", {31'h0, t0}, 32'h1);
        mx_i[0] = 32'hFF; load_i[0] = 1'b1; lv_i[0] = 32'h98;
        tick(1);
        load_i[0] = 1'b0;
        tick(4);
        check("max_ff_99", dout[0], 32'h99);
        tick(4);
        check("max_ff_wrap", dout[0], 32'h00);
        check("max_ff_tc", {31'h0, t0}, 32'h1);

        // Pause mid-prescale.
        mx_i[0] = 32'h59; load_i[0] = 1'b1; lv_i[0] = 32'h10;
        tick(1);
        load_i[0] = 1'b0;
        tick(2);
        run_i[0] = 1'b0;
        tick(10);
        check("hold_digits", dout[0], 32'h10);
        run_i[0] = 1'b1;
        tick(1);
        check("resume_wait", dout[0], 32'h10);
        tick(1);
        check("resume_step", dout[0], 32'h11);
        check("resume_step_pulse", {31'h0, s0}, 32'h1);

        // Asynchronous reset between edges.
        load_i[0] = 1'b1; lv_i[0] = 32'h37;
        tick(1);
        load_i[0] = 1'b0; run_i[0] = 1'b0;
        check("pre_reset", dout[0], 32'h37);
        #2 RST_N = 1'b0;
        #1;
        check("async_reset", dout[0], 32'h00);
        check("async_reset_tc", {31'h0, t0}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1; run_i[0] = 1'b1;
        tick(3);
        check("post_reset_wait", dout[0], 32'h00);
        tick(1);
        check("post_reset_step", dout[0], 32'h01);
        run_i[0] = 1'b0;

        // Instance 1: down from 10 with prescale 1, max 23.
        mx_i[1] = 32'h23; up_i[1] = 1'b0; load_i[1] = 1'b1; lv_i[1] = 32'h10;
        tick(1);
        load_i[1] = 1'b0; run_i[1] = 1'b1;
        check("dn_load", dout[1], 32'h10);
        tick(1);
        check("dn_09", dout[1], 32'h09);
        check("dn_09_step", {31'h0, s1}, 32'h1);
        tick(9);
        check("dn_00", dout[1], 32'h00);
        check("dn_00_tc", {31'h0, t1}, 32'h0);
        tick(1);
        check("dn_wrap", dout[1], 32'h23);
        check("dn_wrap_tc", {31'h0, t1}, 32'h1);
        tick(1);
        check("dn_22", dout[1], 32'h22);
        up_i[1] = 1'b1;
        tick(1);
        check("dir_up", dout[1], 32'h23);
        tick(1);
        check("dir_up_wrap", dout[1], 32'h00);
        check("dir_up_tc", {31'h0, t1}, 32'h1);
        run_i[1] = 1'b0;

        // Instance 2: four digits, prescale 2.
        mx_i[2] = 32'h9999; up_i[2] = 1'b1; load_i[2] = 1'b1; lv_i[2] = 32'h9997;
        tick(1);
        load_i[2] = 1'b0; run_i[2] = 1'b1;
        tick(2);
        check("d4_9998", dout[2], 32'h9998);
        tick(2);
        check("d4_9999", dout[2], 32'h9999);
        tick(2);
        check("d4_wrap", dout[2], 32'h0000);
        check("d4_wrap_tc", {31'h0, t2}, 32'h1);
        run_i[2] = 1'b0; load_i[2] = 1'b1; lv_i[2] = 32'hFA5C;
        tick(1);
        load_i[2] = 1'b0;
        check("d4_load_clamp", dout[2], 32'h9959);
        up_i[2] = 1'b0; load_i[2] = 1'b1; lv_i[2] = 32'h0;
        tick(1);
        load_i[2] = 1'b0; run_i[2] = 1'b1;
        tick(2);
        check("d4_dn_wrap", dout[2], 32'h9999);
        check("d4_dn_tc", {31'h0, t2}, 32'h1);
        run_i[2] = 1'b0;
        tick(2);

        cmp_en = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
